// File: rtl/bitmap_alloc576.sv
// 576-entry free-bitmap allocator: grants the highest-numbered free entry, accepts frees back.
// Optional statistics (hwm, fail_cnt) are built only when BITMAP_ALLOC_STATS_EN is defined.
module bitmap_alloc576 #(
  parameter int unsigned RESV = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_req,
  output logic        alloc_ack,
  output logic [9:0]  alloc_idx,
  input  logic        free_req,
  input  logic [9:0]  free_idx,
  output logic        free_err,
  output logic [9:0]  free_cnt,
  output logic        empty,
  output logic [9:0]  hwm,
  output logic [15:0] fail_cnt
);

  localparam int unsigned N  = 576;
  localparam int unsigned GW = 32;
  localparam int unsigned NG = N / GW;
  localparam logic [9:0]  NONE = 10'd1023;

  function automatic logic [N-1:0] fm_reset_val();
    logic [N-1:0] v;
    for (int k = 0; k < int'(N); k++) v[k] = (k >= int'(RESV));
    return v;
  endfunction

  localparam logic [N-1:0] FM_RST   = fm_reset_val();
  localparam logic [9:0]   CAND_RST = (RESV < N) ? 10'd575 : NONE;
  localparam logic [9:0]   CNT_RST  = 10'(N - RESV);

  logic [N-1:0] r_fm;
  logic [9:0]   r_cand;
  logic [9:0]   r_free_cnt;
  logic         r_empty;
  logic         r_free_err;

  logic          w_ack;
  logic          w_in_range;
  logic          w_legal;
  logic [N-1:0]  w_fm_next;
  logic [NG-1:0] w_grp_any;
  logic [4:0]    w_grp;
  logic          w_grp_hit;
  logic [GW-1:0] w_word;
  logic [4:0]    w_bit;
  logic [9:0]    w_cand_next;
  logic [9:0]    w_cnt_next;

  assign w_ack      = alloc_req & ~r_empty;
  assign w_in_range = (free_idx < 10'(N)) && (int'(free_idx) >= int'(RESV));
  // The current candidate is already free, so freeing it falls out as a double free.
  assign w_legal    = free_req & w_in_range & ~r_fm[free_idx];
  assign w_cnt_next = r_free_cnt - 10'(w_ack) + 10'(w_legal);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_fm_next = r_fm;
    if (w_ack)   w_fm_next[r_cand]   = 1'b0;
    if (w_legal) w_fm_next[free_idx] = 1'b1;
  end

  // Two-level find-first-one: highest non-empty 32-bit group, then highest bit within it.
  always_comb begin
    for (int g = 0; g < int'(NG); g++) w_grp_any[g] = |w_fm_next[g*GW +: GW];
  end

  always_comb begin
    w_grp     = '0;
    w_grp_hit = 1'b0;
    for (int g = 0; g < int'(NG); g++) begin
      if (w_grp_any[g]) begin
        w_grp     = 5'(g);
        w_grp_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int g = 0; g < int'(NG); g++) begin
      if (5'(g) == w_grp) w_word = w_fm_next[g*GW +: GW];
    end
  end

  always_comb begin
    w_bit = '0;
    for (int b = 0; b < int'(GW); b++) begin
      if (w_word[b]) w_bit = 5'(b);
    end
  end

  assign w_cand_next = w_grp_hit ? {w_grp, w_bit} : NONE;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fm       <= FM_RST;
      r_cand     <= CAND_RST;
      r_free_cnt <= CNT_RST;
      r_empty    <= (CNT_RST == 10'd0);
      r_free_err <= 1'b0;
    end else begin
      r_fm       <= w_fm_next;
      r_cand     <= w_cand_next;
      r_free_cnt <= w_cnt_next;
      r_empty    <= (w_cnt_next == 10'd0);
      r_free_err <= free_req & ~w_legal;
    end
  end

  assign alloc_ack = w_ack;
  assign alloc_idx = r_cand;
  assign free_err  = r_free_err;
  assign free_cnt  = r_free_cnt;
  assign empty     = r_empty;

`ifdef BITMAP_ALLOC_STATS_EN
  logic [9:0]  r_hwm;
  logic [15:0] r_fail_cnt;
  logic [9:0]  w_used;

  assign w_used = 10'(N) - r_free_cnt;

  // hwm lags the count by one cycle because it compares against the registered count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hwm      <= 10'(RESV);
      r_fail_cnt <= '0;
    end else begin
      if (w_used > r_hwm) r_hwm <= w_used;
      if (alloc_req && r_empty && (r_fail_cnt != 16'hFFFF)) r_fail_cnt <= r_fail_cnt + 16'd1;
    end
  end

  assign hwm      = r_hwm;
  assign fail_cnt = r_fail_cnt;
`else
  assign hwm      = '0;
  assign fail_cnt = '0;
`endif

  a_cnt_matches_map : assert property (@(posedge clk) disable iff (rst)
    $countones(r_fm) == int'(r_free_cnt));
  a_empty_matches_cnt : assert property (@(posedge clk) disable iff (rst)
    r_empty == (r_free_cnt == 10'd0));
  a_cand_is_free : assert property (@(posedge clk) disable iff (rst)
    r_empty || (r_cand < 10'(N) && r_fm[r_cand]));

endmodule
